obj_spawner: RTL and testbench
==============================

Name: obj_spawner

Overview:
Consumes the per-frame 10-bit pseudo-random value from the game's LFSR generator and turns it into falling on-screen objects. Maintains NUM_OBJ object slots and spawns a new object at a random x position every SPAWN_PERIOD frames. Advances all live objects downward once per frame and retires objects that leave the screen or are cleared by collision logic. Sits between the random-number source and the VGA sprite renderer / collision checker.

Parameters:
NUM_OBJ, 4, number of object slots (1..8)
X_MAX, 617, random values >= X_MAX are rejected as spawn positions
Y_MAX, 480, object retires when its y reaches or exceeds Y_MAX
SPAWN_PERIOD, 30, frames between spawn attempts (>= 1)
FALL_STEP, 2, pixels added to y per frame (1..63)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
frame  in  1  single-cycle pulse, once per video frame (same pulse that drives the generator)
rand_i  in  10  random value from generator; new value valid the cycle after frame
clear_i  in  NUM_OBJ  per-slot clear request from collision logic, any cycle
obj_valid_o  out  NUM_OBJ  slot k holds a live object
obj_x_o  out  10*NUM_OBJ  slot k x at bits [10k+9:10k]
obj_y_o  out  10*NUM_OBJ  slot k y at bits [10k+9:10k]
busy_o  out  1  high while the per-frame update sequence runs
spawn_o  out  1  one-cycle pulse when an object is spawned
miss_o  out  1  one-cycle pulse when at least one object retires off-screen

Behaviour:
- Reset: all outputs 0; all slots invalid with x = y = 0; spawn counter = 0; FSM in IDLE. Reset mid-sequence aborts the sequence immediately.
- FSM states: IDLE, SAMPLE, MOVE, SPAWN.
- IDLE -> SAMPLE on frame (cycle T).
- SAMPLE (T+1): latch rand_i into rand_q; busy_o = 1 from T+1.
- MOVE: one slot per cycle, index 0..NUM_OBJ-1, cycles T+2..T+1+NUM_OBJ.
  - Valid slot: y_next = y + FALL_STEP, computed at 11 bits.
  - If y_next >= Y_MAX: slot becomes invalid; miss flag set.
  - Otherwise: y <= y_next. Invalid slots are untouched.
- SPAWN (cycle T+2+NUM_OBJ):
  - If spawn_cnt == SPAWN_PERIOD-1 AND rand_q < X_MAX AND a free slot exists: the lowest-index free slot gets valid = 1, x = rand_q, y = 0; spawn_o pulses; spawn_cnt <= 0.
  - If spawn_cnt == SPAWN_PERIOD-1 but either condition fails: no spawn; spawn_cnt holds, so the spawn is retried next frame.
  - Otherwise: spawn_cnt <= spawn_cnt + 1.
  - miss_o pulses in this cycle if the miss flag was set; the miss flag then clears.
  - Return to IDLE; busy_o = 0 from the next cycle.
- Total sequence latency: frame to spawn_o is NUM_OBJ+2 cycles.
- clear_i[k] asserted in any cycle: slot k is invalid the next cycle, and x, y are left unchanged.
  - Clear has priority over a same-cycle move of that slot.
  - A slot whose clear is asserted in the SPAWN cycle is not eligible as the free slot that cycle.
  - Clearing an invalid slot has no effect.
- A frame pulse while busy_o = 1 is ignored (no queueing). Spawn_cnt still counts only completed sequences.
- Outputs are registered and change only in the cycles named above, or one cycle after a clear.
- SPAWN_PERIOD = 1: a spawn is attempted every frame.

Decomposition:
- Shared game package holds the constants SCREEN_W = 640, SCREEN_H = 480, COORD_W = 10, and the default X_MAX.
- One natural sub-module: obj_slot, which holds valid/x/y for one slot and has move, clear and load strobes. obj_spawner instantiates NUM_OBJ of these plus the FSM, spawn counter and lowest-free-slot priority encoder.

Test Plan:
- Reset, then frame pulses with rand_i = 100 and SPAWN_PERIOD = 2 -> first frame: no spawn. Second frame: spawn_o at T+6 (NUM_OBJ = 4), slot0 with x = 100, y = 0.
- Live slot0 at y = 476, FALL_STEP = 2 -> y = 478. Next frame: y_next = 480, slot0 invalid, miss_o pulses once at T+6.
- rand_i = 617 at a due frame -> no spawn, spawn_cnt holds. Next frame rand_i = 616 -> spawn with x = 616.
- All 4 slots valid at a due frame -> no spawn. clear_i = 4'b0100 for one cycle -> slot2 invalid. Next frame spawns into slot2.
- clear_i[1] asserted during slot1's MOVE cycle -> slot1 invalid with y unchanged. Frame pulse at T+3 while busy -> ignored, no second sequence.
- rst asserted during MOVE -> the next cycle shows all slots invalid, busy_o = 0, and the next spawn occurs only after SPAWN_PERIOD completed frames.

Source files
------------

// File: rtl/obj_spawner_pkg.sv
// Shared game constants and small helpers for the object spawner.
package obj_spawner_pkg;

  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;
  localparam int unsigned COORD_W   = 10;
  localparam int unsigned X_MAX_DEF = 617;

  // Index/counter width that stays at least one bit for degenerate sizes.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obj_slot.sv
// One falling-object slot: holds valid/x/y and applies load, clear and move strobes.
module obj_slot
  import obj_spawner_pkg::*;
#(
  parameter int unsigned Y_MAX     = SCREEN_H,
  parameter int unsigned FALL_STEP = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               move,
  input  logic               clear,
  input  logic               load,
  input  logic [COORD_W-1:0] load_x,
  output logic               valid,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               retire_c
);

  localparam int unsigned YN_W = COORD_W + 1;
  localparam logic [YN_W-1:0] Y_LIM  = YN_W'(Y_MAX);
  localparam logic [YN_W-1:0] Y_STEP = YN_W'(FALL_STEP);

  logic [YN_W-1:0] y_next;

  // Next y is computed one bit wider so the bottom-edge compare cannot wrap.
  always_comb begin
    y_next   = {1'b0, y} + Y_STEP;
    retire_c = move & valid & ~clear & (y_next >= Y_LIM);
  end

  // Slot state: load only targets a free slot, clear beats a same-cycle move.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      x     <= '0;
      y     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      x     <= load_x;
      y     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (move && valid) begin
      if (y_next >= Y_LIM) valid <= 1'b0;
      else                 y     <= y_next[COORD_W-1:0];
    end
  end

endmodule

// File: rtl/obj_spawner.sv
// Per-frame object sequencer: samples the random value, moves every slot, then tries a spawn.
module obj_spawner
  import obj_spawner_pkg::*;
#(
  parameter int unsigned NUM_OBJ      = 4,
  parameter int unsigned X_MAX        = X_MAX_DEF,
  parameter int unsigned Y_MAX        = SCREEN_H,
  parameter int unsigned SPAWN_PERIOD = 30,
  parameter int unsigned FALL_STEP    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame,
  input  logic [COORD_W-1:0]         rand_i,
  input  logic [NUM_OBJ-1:0]         clear_i,
  output logic [NUM_OBJ-1:0]         obj_valid_o,
  output logic [COORD_W*NUM_OBJ-1:0] obj_x_o,
  output logic [COORD_W*NUM_OBJ-1:0] obj_y_o,
  output logic                       busy_o,
  output logic                       spawn_o,
  output logic                       miss_o
);

  localparam int unsigned IDX_W = idx_width(NUM_OBJ);
  localparam int unsigned CNT_W = idx_width(SPAWN_PERIOD);
  localparam int unsigned XL_W  = COORD_W + 1;
  localparam logic [XL_W-1:0]  X_LIM    = XL_W'(X_MAX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);
  localparam logic [CNT_W-1:0] CNT_DUE  = CNT_W'(SPAWN_PERIOD - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SAMPLE = 2'd1;
  localparam logic [1:0] ST_MOVE   = 2'd2;
  localparam logic [1:0] ST_SPAWN  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [COORD_W-1:0] rand_q;
  logic               miss_q;

  logic [NUM_OBJ-1:0] move_vec, load_vec, retire_c;
  logic [IDX_W-1:0]   free_idx;
  logic               free_any, cnt_due, do_spawn;

  // Lowest-index free slot.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = int'(NUM_OBJ) - 1; i >= 0; i--) begin
      if (!obj_valid_o[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Next state and per-cycle slot strobes.
  always_comb begin
    state_d  = state_q;
    move_vec = '0;
    load_vec = '0;
    do_spawn = 1'b0;
    cnt_due  = (cnt_q == CNT_DUE);
    case (state_q)
      ST_IDLE:   if (frame) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = ST_MOVE;
      ST_MOVE: begin
        move_vec = NUM_OBJ'(1) << idx_q;
        if (idx_q == LAST_IDX) state_d = ST_SPAWN;
      end
      ST_SPAWN: begin
        state_d = ST_IDLE;
        if (cnt_due && ({1'b0, rand_q} < X_LIM) && free_any) begin
          do_spawn = 1'b1;
          load_vec = NUM_OBJ'(1) << free_idx;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any sequence in progress.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Sequence bookkeeping and registered status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      rand_q  <= '0;
      miss_q  <= 1'b0;
      busy_o  <= 1'b0;
      spawn_o <= 1'b0;
      miss_o  <= 1'b0;
    end else begin
      spawn_o <= do_spawn;
      miss_o  <= (state_q == ST_SPAWN) && miss_q;
      case (state_q)
        ST_IDLE: if (frame) busy_o <= 1'b1;
        ST_SAMPLE: begin
          rand_q <= rand_i;
          idx_q  <= '0;
        end
        ST_MOVE: begin
          idx_q <= idx_q + 1'b1;
          if (|retire_c) miss_q <= 1'b1;
        end
        ST_SPAWN: begin
          busy_o <= 1'b0;
          miss_q <= 1'b0;
          if (do_spawn)      cnt_q <= '0;
          else if (!cnt_due) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Slot array.
  for (genvar k = 0; k < NUM_OBJ; k++) begin : g_slot
    obj_slot #(
      .Y_MAX     (Y_MAX),
      .FALL_STEP (FALL_STEP)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .move     (move_vec[k]),
      .clear    (clear_i[k]),
      .load     (load_vec[k]),
      .load_x   (rand_q),
      .valid    (obj_valid_o[k]),
      .x        (obj_x_o[COORD_W*k +: COORD_W]),
      .y        (obj_y_o[COORD_W*k +: COORD_W]),
      .retire_c (retire_c[k])
    );
  end

endmodule

// File: tb/tb_obj_spawner.sv
// Randomized bench for obj_spawner against a frame-level behavioural model.
module tb_obj_spawner;

  localparam int unsigned N  = 4;
  localparam int unsigned XM = 617;
  localparam int unsigned YM = 480;
  localparam int unsigned SP = 2;
  localparam int unsigned FS = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            frame;
  logic [9:0]      rand_i;
  logic [N-1:0]    clear_i;
  logic [N-1:0]    obj_valid_o;
  logic [10*N-1:0] obj_x_o;
  logic [10*N-1:0] obj_y_o;
  logic            busy_o, spawn_o, miss_o;

  always #5 clk = ~clk;

  obj_spawner #(
    .NUM_OBJ(N), .X_MAX(XM), .Y_MAX(YM), .SPAWN_PERIOD(SP), .FALL_STEP(FS)
  ) dut (
    .clk(clk), .rst(rst), .frame(frame), .rand_i(rand_i), .clear_i(clear_i),
    .obj_valid_o(obj_valid_o), .obj_x_o(obj_x_o), .obj_y_o(obj_y_o),
    .busy_o(busy_o), .spawn_o(spawn_o), .miss_o(miss_o)
  );

  int checks = 0;
  int errors = 0;

  bit m_valid[N];
  int m_x[N];
  int m_y[N];
  int m_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_valid[k] = 1'b0; m_x[k] = 0; m_y[k] = 0;
    end
    m_cnt = 0;
  endtask

  // One whole frame: every live object falls, then a spawn attempt on the due frame.
  task automatic model_frame(input int r, input int clr_slot, output bit sp, output bit ms);
    int free_k;
    sp = 1'b0; ms = 1'b0; free_k = -1;
    for (int k = 0; k < N; k++) begin
      if (k == clr_slot) m_valid[k] = 1'b0;
      else if (m_valid[k]) begin
        if (m_y[k] + int'(FS) >= int'(YM)) begin m_valid[k] = 1'b0; ms = 1'b1; end
        else m_y[k] = m_y[k] + int'(FS);
      end
    end
    for (int k = N - 1; k >= 0; k--) if (!m_valid[k]) free_k = k;
    if (m_cnt == int'(SP) - 1) begin
      if (r < int'(XM) && free_k >= 0) begin
        m_valid[free_k] = 1'b1; m_x[free_k] = r; m_y[free_k] = 0;
        m_cnt = 0; sp = 1'b1;
      end
    end else m_cnt++;
  endtask

  task automatic check_slots(input string tag);
    logic [63:0] v, xs, ys;
    v = '0; xs = '0; ys = '0;
    for (int k = 0; k < N; k++) begin
      v[k] = m_valid[k];
      xs[10*k +: 10] = 10'(m_x[k]);
      ys[10*k +: 10] = 10'(m_y[k]);
    end
    check_eq({tag, ".valid"}, 64'(obj_valid_o), v);
    check_eq({tag, ".x"}, 64'(obj_x_o), xs);
    check_eq({tag, ".y"}, 64'(obj_y_o), ys);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      check_eq("idle.busy", 64'(busy_o), 64'd0);
      check_eq("idle.spawn", 64'(spawn_o), 64'd0);
    end
  endtask

  task automatic apply_clear(input logic [N-1:0] mask);
    clear_i = mask;
    @(posedge clk); #1;
    clear_i = '0;
    for (int k = 0; k < N; k++) if (mask[k]) m_valid[k] = 1'b0;
    check_slots("clear");
  endtask

  // Frame edge T, then edges T+1..T+N+2; optional clear of one slot during its move cycle
  // and an optional extra frame pulse while busy.
  task automatic run_frame(input logic [9:0] r, input int clr_slot, input bit extra);
    bit es, em;
    model_frame(int'(r), clr_slot, es, em);
    frame = 1'b1;
    @(posedge clk); #1;
    frame = 1'b0; rand_i = r;
    check_eq("frm.busy0", 64'(busy_o), 64'd1);
    for (int k = 1; k <= N + 2; k++) begin
      if (clr_slot >= 0 && k == clr_slot + 2) clear_i = N'(1) << clr_slot;
      if (extra && k == 3) frame = 1'b1;
      @(posedge clk); #1;
      clear_i = '0; frame = 1'b0;
      rand_i = 10'($urandom);
      check_eq("frm.busy", 64'(busy_o), 64'(k < N + 2));
      check_eq("frm.spawn", 64'(spawn_o), 64'((k == N + 2) ? es : 1'b0));
      check_eq("frm.miss", 64'(miss_o), 64'((k == N + 2) ? em : 1'b0));
    end
    check_slots("frm");
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_slots("rst");
    check_eq("rst.busy", 64'(busy_o), 64'd0);
    check_eq("rst.spawn", 64'(spawn_o), 64'd0);
    check_eq("rst.miss", 64'(miss_o), 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    int cs;
    rst = 1'b1; frame = 1'b0; rand_i = '0; clear_i = '0;
    @(posedge clk); #1;
    reset_dut();

    // First frame only counts; second frame spawns slot0 at x=100.
    run_frame(10'd100, -1, 1'b0);
    run_frame(10'd100, -1, 1'b0);
    check_eq("first_spawn.x0", 64'(obj_x_o[9:0]), 64'd100);

    // Out-of-range x on the due frame holds the counter; next frame retries.
    run_frame(10'd617, -1, 1'b0);
    run_frame(10'd617, -1, 1'b0);
    run_frame(10'd616, -1, 1'b0);
    check_eq("retry_spawn.x1", 64'(obj_x_o[19:10]), 64'd616);

    // Fill all slots, miss a due frame, free slot2 and spawn into it.
    repeat (6) run_frame(10'd5, -1, 1'b0);
    check_eq("full.valid", 64'(obj_valid_o), 64'hF);
    apply_clear(4'b0100);
    run_frame(10'd200, -1, 1'b0);
    check_eq("refill.x2", 64'(obj_x_o[29:20]), 64'd200);

    // Clear slot1 during its move cycle, and a frame pulse while busy is dropped.
    run_frame(10'd300, 1, 1'b1);
    idle(4);

    // Reset in the middle of the move phase.
    frame = 1'b1;
    @(posedge clk); #1;
    frame = 1'b0; rand_i = 10'd50;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_slots("midrst");
    check_eq("midrst.busy", 64'(busy_o), 64'd0);
    idle(2);
    run_frame(10'd50, -1, 1'b0);
    check_eq("midrst.nospawn", 64'(obj_valid_o), 64'd0);
    run_frame(10'd60, -1, 1'b0);
    check_eq("midrst.spawn", 64'(obj_valid_o), 64'd1);

    // Randomized frames, including off-screen retirements.
    for (int f = 0; f < 500; f++) begin
      logic [9:0] r;
      r = ($urandom_range(0, 3) == 0) ? 10'(612 + $urandom_range(0, 8)) : 10'($urandom);
      cs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      run_frame(r, cs, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 19) == 0) apply_clear(N'(1) << $urandom_range(0, N - 1));
      idle(int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
